mat_cache_stream: RTL and testbench

- Handshaked, multi-block WIDTH x WIDTH matrix scratchpad for the matrix unit.
- Takes write, read, clear and in-place transpose commands over a valid/ready command channel.
- Returns read vectors on a valid/ready response channel with a one-entry output register.
- Transpose is a multi-cycle FSM operation, so per-element swap muxing is avoided.

---
 rtl/mat_cache_stream.sv | 209 ++++++++++++++++++++
 tb/tb_mat_cache_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_stream.sv
// mat_cache_stream
//   Multi-block WIDTH x WIDTH matrix scratchpad for the matrix unit. Rows,
//   columns and wrapped diagonals can be written and read through a
//   valid/ready command channel. Whole blocks can be cleared in one cycle or
//   transposed in place. Read results come back through a one-entry
//   valid/ready response register.
//
//   Elements are opaque DATA_WIDTH-bit words (raw IEEE-754 single bits).
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high; zeroes the cache and aborts a transpose
//   cmd_valid  command present
//   cmd_ready  command accepted on cmd_valid && cmd_ready at the clock edge
//   cmd_op     0 WRITE_DIAG, 1 WRITE_ROW, 2 WRITE_COL, 3 READ_DIAG,
//              4 READ_ROW, 5 READ_COL, 6 TRANSPOSE, 7 CLEAR
//   cmd_addr1  primary block
//   cmd_addr2  secondary block (diagonal ops only)
//   cmd_param  row / column / diagonal index
//   cmd_data   write vector, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid  read result held
//   rsp_ready  consumer takes the result
//   rsp_data   read vector, same lane packing as cmd_data
//   busy       transpose in progress
module mat_cache_stream #(
    parameter int WIDTH           = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int CACHE_SIZE      = 4,
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE),
    parameter int PARAM_SIZE      = 1 + $clog2(WIDTH)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [CACHE_ADDR_SIZE-1:0]       cmd_addr1,
    input  logic [CACHE_ADDR_SIZE-1:0]       cmd_addr2,
    input  logic [PARAM_SIZE-1:0]            cmd_param,
    input  logic [WIDTH*DATA_WIDTH-1:0]      cmd_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [WIDTH*DATA_WIDTH-1:0]      rsp_data,
    output logic                             busy
);

    // Element index width inside one block (at least one bit).
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Wrapped-diagonal column WIDTH+p-i needs one extra bit before truncation.
    localparam int PW1 = PARAM_SIZE + 1;

    localparam logic [2:0] OP_WDIAG = 3'd0;
    localparam logic [2:0] OP_WROW  = 3'd1;
    localparam logic [2:0] OP_WCOL  = 3'd2;
    localparam logic [2:0] OP_RDIAG = 3'd3;
    localparam logic [2:0] OP_RROW  = 3'd4;
    localparam logic [2:0] OP_RCOL  = 3'd5;
    localparam logic [2:0] OP_XPOSE = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_XPOSE
    } state_t;

    state_t                       r_state;
    logic [CACHE_ADDR_SIZE-1:0]   r_xp_blk;
    logic [IW-1:0]                r_xp_row;
    logic [DATA_WIDTH-1:0]        r_mem [CACHE_SIZE][WIDTH][WIDTH];
    logic                         r_rsp_valid;
    logic [WIDTH*DATA_WIDTH-1:0]  r_rsp_data;

    logic                                       w_accept;
    logic                                       w_in_range;
    logic                                       w_is_read;
    logic [IW-1:0]                              w_p;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]           w_lane;
    logic [WIDTH-1:0][CACHE_ADDR_SIZE-1:0]      w_dg_blk;
    logic [WIDTH-1:0][IW-1:0]                   w_dg_col;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]           w_rd_vec;

    // Held low during reset so nothing is accepted while the cache is cleared.
    assign cmd_ready  = !reset && (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_in_range = (cmd_param < PARAM_SIZE'(WIDTH));
    assign w_is_read  = (cmd_op == OP_RDIAG) || (cmd_op == OP_RROW) || (cmd_op == OP_RCOL);
    assign w_p        = cmd_param[IW-1:0];
    assign w_lane     = cmd_data;

    assign busy      = (r_state == ST_XPOSE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // Per-lane diagonal mapping and read mux. Lane i of diagonal p sits at
    // column p-i of the primary block while i <= p, and wraps into the
    // secondary block at column WIDTH+p-i otherwise.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        localparam logic [PW1-1:0] LANE_W = PW1'(gi);
        localparam logic [IW-1:0]  LANE_I = IW'(gi);
        logic w_lo;

        assign w_lo          = (cmd_param >= PARAM_SIZE'(gi));
        assign w_dg_blk[gi]  = w_lo ? cmd_addr1 : cmd_addr2;
        assign w_dg_col[gi]  = IW'(w_lo ? ({1'b0, cmd_param} - LANE_W)
                                        : (PW1'(WIDTH) + {1'b0, cmd_param} - LANE_W));

        // Out-of-range index reads back as zero.
        assign w_rd_vec[gi] =
            !w_in_range           ? '0 :
            (cmd_op == OP_RDIAG)  ? r_mem[w_dg_blk[gi]][LANE_I][w_dg_col[gi]] :
            (cmd_op == OP_RROW)   ? r_mem[cmd_addr1][w_p][LANE_I] :
            (cmd_op == OP_RCOL)   ? r_mem[cmd_addr1][LANE_I][w_p] :
                                    '0;
    end

    // Control FSM and cache storage. Writes commit on the accepting edge;
    // a transpose walks one row per cycle swapping the strict upper triangle
    // of that row with the matching column.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_xp_blk <= '0;
            r_xp_row <= '0;
            for (int c = 0; c < CACHE_SIZE; c++) begin
                for (int r = 0; r < WIDTH; r++) begin
                    for (int k = 0; k < WIDTH; k++) begin
                        r_mem[CACHE_ADDR_SIZE'(c)][IW'(r)][IW'(k)] <= '0;
                    end
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_WDIAG: begin
                                if (w_in_range) begin
                                    for (int i = 0; i < WIDTH; i++) begin
                                        r_mem[w_dg_blk[IW'(i)]][IW'(i)][w_dg_col[IW'(i)]] <= w_lane[IW'(i)];
                                    end
                                end
                            end
                            OP_WROW: begin
                                if (w_in_range) begin
                                    for (int j = 0; j < WIDTH; j++) begin
                                        r_mem[cmd_addr1][w_p][IW'(j)] <= w_lane[IW'(j)];
                                    end
                                end
                            end
                            OP_WCOL: begin
                                if (w_in_range) begin
                                    for (int i = 0; i < WIDTH; i++) begin
                                        r_mem[cmd_addr1][IW'(i)][w_p] <= w_lane[IW'(i)];
                                    end
                                end
                            end
                            OP_CLEAR: begin
                                for (int r = 0; r < WIDTH; r++) begin
                                    for (int k = 0; k < WIDTH; k++) begin
                                        r_mem[cmd_addr1][IW'(r)][IW'(k)] <= '0;
                                    end
                                end
                            end
                            OP_XPOSE: begin
                                // A 1x1 block is its own transpose.
                                if (WIDTH > 1) begin
                                    r_state  <= ST_XPOSE;
                                    r_xp_blk <= cmd_addr1;
                                    r_xp_row <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_XPOSE: begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (IW'(j) > r_xp_row) begin
                            r_mem[r_xp_blk][r_xp_row][IW'(j)] <= r_mem[r_xp_blk][IW'(j)][r_xp_row];
                            r_mem[r_xp_blk][IW'(j)][r_xp_row] <= r_mem[r_xp_blk][r_xp_row][IW'(j)];
                        end
                    end
                    // Row WIDTH-2 is the last with anything above the diagonal.
                    if (r_xp_row == IW'(WIDTH - 2)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_xp_row <= r_xp_row + IW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Response register: loads on an accepted read, otherwise empties once
    // the consumer takes it. A read accepted on the draining edge keeps it full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_accept && w_is_read) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_vec;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mat_cache_stream.sv
module tb_mat_cache_stream;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int CS = 4;
    localparam int AW = 2;
    localparam int PS = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [AW-1:0]   cmd_addr1;
    logic [AW-1:0]   cmd_addr2;
    logic [PS-1:0]   cmd_param;
    logic [W*DW-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [W*DW-1:0] rsp_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference contents: mdl[block][row][col]
    logic [DW-1:0] mdl [CS][W][W];

    mat_cache_stream #(
        .WIDTH(W), .DATA_WIDTH(DW), .CACHE_SIZE(CS)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_param(cmd_param),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W*DW-1:0] pk(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Expected read result, straight from the index rules.
    function automatic logic [W*DW-1:0] m_read(input int op, input int a1, input int a2, input int p);
        logic [W*DW-1:0] v;
        v = '0;
        if (p < W) begin
            for (int i = 0; i < W; i++) begin
                if (op == 4)      v[i*DW +: DW] = mdl[a1][p][i];
                else if (op == 5) v[i*DW +: DW] = mdl[a1][i][p];
                else if (op == 3) v[i*DW +: DW] = (i <= p) ? mdl[a1][i][p-i] : mdl[a2][i][W+p-i];
            end
        end
        return v;
    endfunction

    task automatic m_exec(input int op, input int a1, input int a2, input int p, input logic [W*DW-1:0] d);
        logic [DW-1:0] t [W][W];
        case (op)
            0: if (p < W) for (int i = 0; i < W; i++)
                   if (i <= p) mdl[a1][i][p-i] = d[i*DW +: DW];
                   else        mdl[a2][i][W+p-i] = d[i*DW +: DW];
            1: if (p < W) for (int j = 0; j < W; j++) mdl[a1][p][j] = d[j*DW +: DW];
            2: if (p < W) for (int i = 0; i < W; i++) mdl[a1][i][p] = d[i*DW +: DW];
            6: begin
                for (int i = 0; i < W; i++) for (int j = 0; j < W; j++) t[i][j] = mdl[a1][i][j];
                for (int i = 0; i < W; i++) for (int j = 0; j < W; j++) mdl[a1][i][j] = t[j][i];
            end
            7: for (int i = 0; i < W; i++) for (int j = 0; j < W; j++) mdl[a1][i][j] = '0;
            default: ;
        endcase
    endtask

    task automatic model_zero();
        for (int b = 0; b < CS; b++) for (int i = 0; i < W; i++) for (int j = 0; j < W; j++) mdl[b][i][j] = '0;
    endtask

    task automatic chkv(input string tag, input logic [W*DW-1:0] obs, input logic [W*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command, wait (bounded) for acceptance, update the model and
    // check any read result one cycle later. Returns at accept edge + 1.
    task automatic send(input int op, input int a1, input int a2, input int p, input logic [W*DW-1:0] d);
        logic [W*DW-1:0] exp;
        int n;
        exp       = m_read(op, a1, a2, p);
        cmd_op    = 3'(op);
        cmd_addr1 = AW'(a1);
        cmd_addr2 = AW'(a2);
        cmd_param = PS'(p);
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        #1;
        while (!cmd_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chkb("cmd_accept", cmd_ready, 1'b1);
        @(posedge clock);
        m_exec(op, a1, a2, p, d);
        #1;
        cmd_valid = 1'b0;
        if (op == 3 || op == 4 || op == 5) begin
            chkb("rd_rsp_valid", rsp_valid, 1'b1);
            chkv("rd_rsp_data", rsp_data, exp);
        end
    endtask

    initial begin
        int nb, nr, n, op, a1, a2, p;
        logic [W*DW-1:0] d, exp1;

        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = '0; cmd_addr1 = '0; cmd_addr2 = '0; cmd_param = '0; cmd_data = '0;
        model_zero();

        // Reset state
        #2;
        chkb("rst_cmd_ready", cmd_ready, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkv("rst_rsp_data", rsp_data, '0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1 chkb("post_rst_ready", cmd_ready, 1'b1);

        // Row / column write-read
        send(1, 1, 0, 2, pk(1, 2, 3, 4));
        send(5, 1, 0, 3, '0);
        chkv("col_read_const", rsp_data, pk(0, 0, 4, 0));
        send(4, 1, 0, 2, '0);
        chkv("row_read_const", rsp_data, pk(1, 2, 3, 4));

        // Diagonal split across two blocks
        send(0, 0, 2, 1, pk(10, 11, 12, 13));
        send(4, 0, 0, 0, '0); chkv("diag_blk0_r0", rsp_data, pk(0, 10, 0, 0));
        send(4, 0, 0, 1, '0); chkv("diag_blk0_r1", rsp_data, pk(11, 0, 0, 0));
        send(4, 2, 0, 2, '0); chkv("diag_blk2_r2", rsp_data, pk(0, 0, 0, 12));
        send(4, 2, 0, 3, '0); chkv("diag_blk2_r3", rsp_data, pk(0, 0, 13, 0));
        send(3, 0, 2, 1, '0); chkv("diag_read", rsp_data, pk(10, 11, 12, 13));

        // Transpose
        for (int r = 0; r < W; r++) send(1, 3, 0, r, pk(4*r, 4*r+1, 4*r+2, 4*r+3));
        send(6, 3, 0, 0, '0);
        nb = 0; nr = 0; n = 0;
        while (busy && n < 20) begin
            nb++;
            if (cmd_ready) nr++;
            @(posedge clock); #1;
            n++;
        end
        chki("xpose_busy_cycles", nb, W - 1);
        chki("xpose_ready_high_cycles", nr, 0);
        chkb("xpose_done_ready", cmd_ready, 1'b1);
        send(4, 3, 0, 0, '0);
        chkv("xpose_row0", rsp_data, pk(0, 4, 8, 12));
        for (int r = 1; r < W; r++) send(4, 3, 0, r, '0);

        // Backpressure
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        send(4, 3, 0, 1, '0);
        exp1 = m_read(4, 3, 0, 1);
        cmd_op = 3'd4; cmd_addr1 = 2'd3; cmd_param = 3'd2; cmd_valid = 1'b1;
        #1 chkb("bp_ready_low", cmd_ready, 1'b0);
        repeat (2) begin
            @(posedge clock); #1;
            chkb("bp_valid_held", rsp_valid, 1'b1);
            chkv("bp_data_held", rsp_data, exp1);
        end
        rsp_ready = 1'b1;
        #1 chkb("bp_ready_on_drain", cmd_ready, 1'b1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        chkb("bp_valid_stays", rsp_valid, 1'b1);
        chkv("bp_second_data", rsp_data, m_read(4, 3, 0, 2));
        @(posedge clock); #1;
        chkb("bp_drained", rsp_valid, 1'b0);

        // Range check and clear
        send(4, 3, 0, 5, '0);
        chkv("range_read_zero", rsp_data, '0);
        send(1, 3, 0, 6, pk($urandom, $urandom, $urandom, $urandom));
        for (int r = 0; r < W; r++) send(4, 3, 0, r, '0);
        send(7, 1, 0, 0, '0);
        send(4, 1, 0, 2, '0);
        chkv("clear_row_zero", rsp_data, '0);

        // Randomized command mix against the model
        repeat (120) begin
            op = int'($urandom_range(0, 7));
            a1 = int'($urandom_range(0, CS-1));
            a2 = int'($urandom_range(0, CS-1));
            p  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(W, 7)) : int'($urandom_range(0, W-1));
            d  = pk($urandom, $urandom, $urandom, $urandom);
            send(op, a1, a2, p, d);
        end
        for (int b = 0; b < CS; b++) for (int r = 0; r < W; r++) send(4, b, 0, r, '0);

        // Reset mid-transpose
        for (int r = 0; r < W; r++) send(1, 0, 0, r, pk($urandom | 1, $urandom, $urandom, $urandom));
        send(6, 0, 0, 0, '0);
        chkb("mid_xpose_busy", busy, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chkb("mid_rst_busy", busy, 1'b0);
        chkb("mid_rst_valid", rsp_valid, 1'b0);
        chkb("mid_rst_ready", cmd_ready, 1'b0);
        chkv("mid_rst_data", rsp_data, '0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_zero();
        #1 chkb("after_rst_ready", cmd_ready, 1'b1);
        for (int b = 0; b < CS; b++) for (int r = 0; r < W; r++) send(4, b, 0, r, '0);
        send(3, 0, 1, 2, '0);
        chkv("after_rst_diag_zero", rsp_data, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
